// File: rtl/fifo_sample_reader.sv
// Pulls samples from a sync_fifo into a 2-entry holding buffer and presents them to the decoder.
// A decoder rewind flushes the buffer and moves the FIFO read pointer back through a jump strobe.
`timescale 1ns/1ps
module fifo_sample_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_jump,
  output logic [ADDR_WIDTH-1:0] fifo_jump_value,
  input  logic                  fifo_jump_error,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  rewind_req,
  input  logic [ADDR_WIDTH-1:0] rewind_count,
  output logic                  rewind_done,
  output logic                  rewind_err,
  output logic [15:0]           sample_count
);

  localparam logic [1:0] ST_READ  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_JUMP  = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

  logic [1:0]            state_r;
  logic                  run_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;
  logic [1:0]            buf_cnt_r;
  logic                  inflight_r;
  logic [ADDR_WIDTH-1:0] rewind_cnt_r;
  logic [ADDR_WIDTH-1:0] jump_value_r;
  logic                  jump_r;
  logic                  done_r;
  logic                  err_r;
  logic [15:0]           sample_count_r;

  logic                  in_read_s;
  logic                  accept_s;
  logic                  valid_s;
  logic                  hs_s;
  logic [2:0]            pending_s;
  logic                  rd_en_s;
  logic                  flush_now_s;
  logic [1:0]            cnt_pop_s;
  logic [ADDR_WIDTH:0]   jump_sum_s;
  logic [DATA_WIDTH-1:0] buf0_n;
  logic [DATA_WIDTH-1:0] buf1_n;
  logic [1:0]            cnt_n;

  // Output valid is suppressed from the cycle a rewind is accepted until READ resumes.
  assign in_read_s   = (state_r == ST_READ);
  assign accept_s    = in_read_s && rewind_req;
  assign valid_s     = in_read_s && !rewind_req && (buf_cnt_r != 2'd0);
  assign hs_s        = valid_s && out_ready;
  assign pending_s   = {1'b0, buf_cnt_r} + {2'b00, inflight_r} - {2'b00, hs_s};
  assign rd_en_s     = run_r && in_read_s && !rewind_req && enable && !fifo_empty &&
                       (pending_s < 3'd2);
  assign flush_now_s = (state_r == ST_FLUSH) && !inflight_r;
  assign cnt_pop_s   = buf_cnt_r - {1'b0, hs_s};
  assign jump_sum_s  = {1'b0, rewind_cnt_r} + {{(ADDR_WIDTH-1){1'b0}}, buf_cnt_r};

  assign fifo_rd_en      = rd_en_s;
  assign fifo_jump       = jump_r;
  assign fifo_jump_value = jump_value_r;
  assign out_data        = buf0_r;
  assign out_valid       = valid_s;
  assign rewind_done     = done_r;
  assign rewind_err      = err_r;
  assign sample_count    = sample_count_r;

  // Next holding-buffer contents: retire the head on handshake, then append landing read data.
  always_comb begin
    buf1_n = buf1_r;
    if (hs_s) begin
      buf0_n = buf1_r;
    end else begin
      buf0_n = buf0_r;
    end
    if (flush_now_s) begin
      cnt_n = 2'd0;
    end else if (inflight_r) begin
      cnt_n = cnt_pop_s + 2'd1;
      case (cnt_pop_s)
        2'd0:    buf0_n = fifo_rd_data;
        default: buf1_n = fifo_rd_data;
      endcase
    end else begin
      cnt_n = cnt_pop_s;
    end
  end

  // Datapath registers: buffer, read-in-flight tracker and delivered-sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_r          <= 1'b0;
      buf0_r         <= '0;
      buf1_r         <= '0;
      buf_cnt_r      <= 2'd0;
      inflight_r     <= 1'b0;
      sample_count_r <= 16'd0;
    end else begin
      run_r      <= 1'b1;
      buf0_r     <= buf0_n;
      buf1_r     <= buf1_n;
      buf_cnt_r  <= cnt_n;
      inflight_r <= rd_en_s;
      if (hs_s) begin
        sample_count_r <= sample_count_r + 16'd1;
      end
    end
  end

  // Rewind sequencer: fifo_jump and the result pulses are registered one-cycle strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_READ;
      rewind_cnt_r <= '0;
      jump_value_r <= '0;
      jump_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      jump_r       <= 1'b0;
      jump_value_r <= '0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      case (state_r)
        ST_READ: begin
          if (accept_s) begin
            rewind_cnt_r <= rewind_count;
            state_r      <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The jump also covers buffered-but-undelivered samples, so they are re-read.
          if (!inflight_r) begin
            if (jump_sum_s[ADDR_WIDTH]) begin
              err_r   <= 1'b1;
              state_r <= ST_READ;
            end else begin
              jump_r       <= 1'b1;
              jump_value_r <= jump_sum_s[ADDR_WIDTH-1:0];
              state_r      <= ST_JUMP;
            end
          end
        end
        ST_JUMP: begin
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          if (fifo_jump_error) begin
            err_r <= 1'b1;
          end else begin
            done_r <= 1'b1;
          end
          state_r <= ST_READ;
        end
        default: begin
          state_r <= ST_READ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader with a sync_fifo stand-in and a delivery-order model.
`timescale 1ns/1ps
module tb_fifo_sample_reader;
  localparam int DW = 12;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_jump;
  logic [AW-1:0] fifo_jump_value;
  logic          fifo_jump_error;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          rewind_req = 1'b0;
  logic [AW-1:0] rewind_count = '0;
  logic          rewind_done;
  logic          rewind_err;
  logic [15:0]   sample_count;

  fifo_sample_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_jump(fifo_jump), .fifo_jump_value(fifo_jump_value), .fifo_jump_error(fifo_jump_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .rewind_req(rewind_req), .rewind_count(rewind_count),
    .rewind_done(rewind_done), .rewind_err(rewind_err), .sample_count(sample_count)
  );

  initial forever #5 clk = ~clk;

  // sync_fifo stand-in: registered read data, pointer jump rejected if too far or forced.
  logic [DW-1:0] mem [0:31];
  int rd_ptr;
  int wr_cnt = 0;
  bit reject = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 0;
      fifo_rd_data <= '0;
      fifo_jump_error <= 1'b0;
    end else begin
      fifo_jump_error <= 1'b0;
      if (fifo_rd_en) begin
        fifo_rd_data <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
      if (fifo_jump) begin
        if (reject || int'(fifo_jump_value) > rd_ptr) fifo_jump_error <= 1'b1;
        else rd_ptr <= rd_ptr - int'(fifo_jump_value);
      end
    end
  end
  assign fifo_empty = (rd_ptr >= wr_cnt);

  int n_cmp = 0;
  int n_err = 0;
  int dp = 0, msc = 0, hs_total = 0, rd_issued = 0, jump_seen = 0, done_seen = 0, err_seen = 0;
  int last_jval = 0, last_out = 0, cyc = 0, first_hs = 0, last_hs = 0, req_cnt = 0;
  bit prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Decoder-side model: next expected sample is mem[dp]; a successful rewind moves dp back.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        dp = 0; msc = 0; hs_total = 0; rd_issued = 0; jump_seen = 0; done_seen = 0;
        err_seen = 0; last_jval = 0; last_out = 0; cyc = 0; prev_hold = 1'b0;
      end else begin
        cyc++;
        chk("sample_count", int'(sample_count), msc);
        chk("rd_en_while_empty", int'(fifo_rd_en && fifo_empty), 0);
        chk("jump_value_idle", fifo_jump ? 0 : int'(fifo_jump_value), 0);
        if (fifo_rd_en) rd_issued++;
        if (prev_hold && out_valid) chk("hold_stable", int'(out_data), int'(prev_data));
        if (out_valid && out_ready) begin
          chk("out_data", int'(out_data), int'(mem[dp]));
          dp++;
          msc = (msc + 1) & 16'hFFFF;
          hs_total++;
          if (hs_total == 1) first_hs = cyc;
          last_hs = cyc;
          last_out = int'(out_data);
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (fifo_jump) begin
          jump_seen++;
          last_jval = int'(fifo_jump_value);
        end
        if (rewind_done) begin
          done_seen++;
          dp -= req_cnt;
        end
        if (rewind_err) begin
          err_seen++;
          dp = rd_ptr;
        end
      end
    end
  endtask

  task automatic start(input int n, input bit ready);
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b0; rewind_req = 1'b0; reject = 1'b0;
    wr_cnt = n;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; enable = 1'b1; out_ready = ready;
  endtask

  // Deliver samples 1..4 then stall so 5 and 6 sit in the holding buffer.
  task automatic prefix();
    int k;
    start(6, 1'b1);
    k = 0;
    while (hs_total < 4 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    chk("prefix_delivered", hs_total, 4);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic rewind(input int cnt);
    req_cnt = cnt;
    rewind_count = AW'(cnt);
    rewind_req = 1'b1;
    @(posedge clk); #1;
    rewind_req = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
  endtask

  task automatic run(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = DW'(i + 1);
    fork monitor(); join_none

    // Reset values with a non-empty FIFO and enable high
    wr_cnt = 6; enable = 1'b1; out_ready = 1'b1;
    run(2);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_jump", int'(fifo_jump), 0);
    chk("rst_pulses", int'(rewind_done) + int'(rewind_err), 0);
    chk("rst_sample_count", int'(sample_count), 0);
    rst_n = 1'b1; #1;
    chk("rd_en_at_release", int'(fifo_rd_en), 0);
    @(posedge clk); #1;
    chk("first_read", int'(fifo_rd_en), 1);

    // Streaming 1..6 back to back
    run(12);
    chk("stream_count", hs_total, 6);
    chk("stream_consecutive", last_hs - first_hs, 5);
    chk("stream_last", last_out, 6);
    chk("stream_sample_count", int'(sample_count), 6);

    // Backpressure for 10 cycles
    start(8, 1'b0);
    run(10);
    chk("bp_reads", rd_issued, 2);
    chk("bp_head", int'(out_data), 1);
    chk("bp_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    run(15);
    chk("bp_delivered", hs_total, 8);
    chk("bp_sample_count", int'(sample_count), 8);

    // Rewind 3 with two buffered samples
    prefix();
    rewind(3);
    chk("rw_jump_count", jump_seen, 1);
    chk("rw_jump_value", last_jval, 5);
    chk("rw_done", done_seen, 1);
    chk("rw_err", err_seen, 0);
    chk("rw_model_ptr", dp, 1);
    chk("rw_sample_count", int'(sample_count), 4);
    out_ready = 1'b1;
    run(12);
    chk("rw_delivered", hs_total, 9);
    chk("rw_last", last_out, 6);

    // Rewind 0 replays the buffered samples only
    prefix();
    rewind(0);
    chk("rw0_jump_value", last_jval, 2);
    chk("rw0_done", done_seen, 1);
    out_ready = 1'b1;
    run(8);
    chk("rw0_delivered", hs_total, 6);
    chk("rw0_last", last_out, 6);

    // Jump overflow: 6 + 2 > 7
    prefix();
    rewind(6);
    chk("ovf_jump", jump_seen, 0);
    chk("ovf_err", err_seen, 1);
    chk("ovf_done", done_seen, 0);
    chk("ovf_valid", int'(out_valid), 0);
    wr_cnt = 8; out_ready = 1'b1;
    run(8);
    chk("ovf_delivered", hs_total, 6);
    chk("ovf_last", last_out, 8);

    // FIFO rejects the jump
    prefix();
    reject = 1'b1;
    rewind(1);
    chk("rej_jump", jump_seen, 1);
    chk("rej_jump_value", last_jval, 3);
    chk("rej_err", err_seen, 1);
    chk("rej_done", done_seen, 0);
    reject = 1'b0; wr_cnt = 8; out_ready = 1'b1;
    run(8);
    chk("rej_delivered", hs_total, 6);
    chk("rej_last", last_out, 8);

    // Reset while flushing
    prefix();
    req_cnt = 2; rewind_count = 3'd2; rewind_req = 1'b1;
    @(posedge clk); #1;
    rewind_req = 1'b0;
    rst_n = 1'b0; #1;
    chk("flrst_rd_en", int'(fifo_rd_en), 0);
    chk("flrst_jump", int'(fifo_jump) + int'(fifo_jump_value), 0);
    chk("flrst_valid", int'(out_valid), 0);
    chk("flrst_data", int'(out_data), 0);
    chk("flrst_pulses", int'(rewind_done) + int'(rewind_err), 0);
    chk("flrst_sample_count", int'(sample_count), 0);
    run(2);
    rst_n = 1'b1; enable = 1'b0;
    run(8);
    chk("flrst_no_jump", jump_seen, 0);
    chk("flrst_no_pulse", done_seen + err_seen, 0);
    chk("flrst_count_after", int'(sample_count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_sample_reader.md
FIFO_SAMPLE_READER -- requirements
Module: fifo_sample_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, sample width; matches sync_fifo DATA_WIDTH.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, FIFO address width; sets jump/rewind field width.
REQ-003 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  permits new FIFO reads
- fifo_empty  in  1  sync_fifo empty flag
- fifo_rd_en  out  1  sync_fifo read strobe
- fifo_rd_data  in  DATA_WIDTH  sync_fifo read data
- fifo_jump  out  1  one-cycle sync_fifo read-pointer jump strobe
- fifo_jump_value  out  ADDR_WIDTH  entries to move the read pointer back
- fifo_jump_error  in  1  sync_fifo jump rejected
- out_data  out  DATA_WIDTH  sample to decoder
- out_valid  out  1  out_data valid
- out_ready  in  1  decoder accepts
- rewind_req  in  1  decoder requests replay of delivered samples
- rewind_count  in  ADDR_WIDTH  number of delivered samples to replay
- rewind_done  out  1  one-cycle pulse, rewind succeeded
- rewind_err  out  1  one-cycle pulse, rewind failed
- sample_count  out  16  delivered-sample counter

Function
REQ-004 SHALL treat fifo_rd_data as valid exactly one cycle after a cycle with fifo_rd_en=1 (read in flight).
REQ-005 SHALL hold popped samples in a 2-entry in-order holding buffer; out_data/out_valid SHALL come from the buffer head.
REQ-006 SHALL assert fifo_rd_en only when state=READ, enable=1, fifo_empty=0, and (buffer occupancy + in-flight - handshake this cycle) < 2.
REQ-007 SHALL never assert fifo_rd_en while fifo_empty=1; buffer SHALL never overflow.
REQ-008 SHALL complete the handshake when out_valid&out_ready; head retires that cycle; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-009 SHALL sustain one sample per cycle when FIFO is non-empty and out_ready is held at 1.
REQ-010 SHALL increment sample_count by 1 per handshake, wrapping 0xFFFF->0.
REQ-011 SHALL, with enable=0, issue no new reads but land in-flight data and keep draining the buffer.
REQ-012 SHALL implement states READ, FLUSH, JUMP, CHECK.
REQ-013 READ: SHALL accept rewind_req only in READ; rewind_req in other states SHALL be ignored; rewind_count SHALL be captured on acceptance.
REQ-014 READ->FLUSH on accepted rewind_req; that cycle fifo_rd_en=0 and no handshake SHALL complete (out_valid forced 0 from this cycle until return to READ).
REQ-015 FLUSH: SHALL wait for any in-flight read to land, then compute jump = captured count + buffer occupancy B, discard the buffer, and go to JUMP.
REQ-016 FLUSH: if jump > 2^ADDR_WIDTH-1, SHALL pulse rewind_err, issue no fifo_jump, discard buffer, and return to READ.
REQ-017 JUMP: SHALL assert fifo_jump=1 for exactly one cycle with fifo_jump_value=jump, then go to CHECK; fifo_jump_value SHALL be 0 whenever fifo_jump=0.
REQ-018 CHECK: SHALL sample fifo_jump_error; if 1 pulse rewind_err, else pulse rewind_done; SHALL then return to READ.
REQ-019 rewind_count=0 SHALL still flush and jump back by B (replays buffered, undelivered samples).
REQ-020 sample_count SHALL NOT be altered by a rewind.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=READ, buffer empty, in-flight cleared, fifo_rd_en=0, fifo_jump=0, fifo_jump_value=0, out_valid=0, out_data=0, rewind_done=0, rewind_err=0, sample_count=0.
REQ-022 Reset mid-rewind SHALL abandon it with no fifo_jump or pulse emitted after reset release.
REQ-023 First fifo_rd_en SHALL occur no earlier than the first clock edge after rst_n deasserts.

Verification
REQ-024 Stream: FIFO preloaded 1..6, out_ready=1 -> out_data 1,2,3,4,5,6 on consecutive cycles, sample_count=6, fifo_rd_en never with fifo_empty=1.
REQ-025 Backpressure: out_ready=0 for 10 cycles with FIFO non-empty -> out_data held, at most 2 reads issued, no loss or duplication after release.
REQ-026 Rewind: after delivering 1..4 with B=2 (5,6 buffered), rewind_count=3 -> fifo_jump_value=5, rewind_done pulse, next delivered 2,3,4,5,6.
REQ-027 Overflow: ADDR_WIDTH=3, B=2, rewind_count=6 -> rewind_err pulse, no fifo_jump, buffer discarded.
REQ-028 Jump reject: fifo_jump_error=1 in CHECK -> rewind_err pulse, no rewind_done, state READ next cycle.
REQ-029 Reset during FLUSH -> all outputs 0 immediately, no fifo_jump afterward, sample_count=0.
